line_memory_responder: RTL and testbench



---
 rtl/line_memory_responder.sv | 143 ++++++++++++++
 tb/tb_line_memory_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_memory_responder.sv
// Backing-store responder for the cache line interface: one outstanding
// request, fixed read/write latency, one-cycle rdy pulse, then a dead
// turnaround window before the next request can be sampled.
module line_memory_responder #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LINE_AW = 14,
    parameter int unsigned RD_LAT  = 4,
    parameter int unsigned WR_LAT  = 4,
    parameter int unsigned TURN    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdy,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 1 << LINE_AW;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        TURNAROUND
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rw_q, rw_d;
    logic [LINE_AW-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    rdata_q;
    logic                 rdy_q, rdy_d;
    logic                 busy_q, busy_d;
    logic                 accept_c;
    logic                 commit_c;
    logic                 addr_unused_c;

    logic [DATA_W-1:0]    mem_q [DEPTH];

    // Byte-offset bits never select anything inside a line.
    assign addr_unused_c = ^addr[1:0];

    // Next-state, request capture and registered-output selection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rw_d     = rw_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        accept_c = 1'b0;
        commit_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    accept_c = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d  = RESP;
                    commit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = TURNAROUND;
                cnt_d   = CNT_W'(TURN - 1);
            end
            TURNAROUND: begin
                // The closing turnaround edge doubles as a sampling slot so a
                // held req restarts with spacing LAT+1+TURN.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (req) begin
                    accept_c = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Even LAT=1 spends one ACCESS cycle (counter 0) so rdy lands after edge t+LAT.
        if (accept_c) begin
            state_d = ACCESS;
            rw_d    = rw;
            idx_d   = addr[LINE_AW+1:2];
            wdata_d = wdata;
            cnt_d   = rw ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
        end

        rdy_d  = commit_c;
        busy_d = (state_d != IDLE);
    end

    // State, latched request and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            if (commit_c && !rw_q) begin
                rdata_q <= mem_q[idx_q];
            end
        end
    end

    // Line array; a write that reaches the RESP edge commits even if rst lands on it.
    always_ff @(posedge clk) begin
        if (commit_c && rw_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign rdata = rdata_q;
    assign rdy   = rdy_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_line_memory_responder.sv
// Scoreboard bench for line_memory_responder: two instances (default latency
// and RD_LAT=1/WR_LAT=7), expected rdy cycle and rdata queued at issue time.
module tb_line_memory_responder;

    localparam int TURN = 2;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_s   [2];
    logic        rw_s    [2];
    logic [15:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_s [2];
    logic        rdy_s   [2];
    logic        busy_s  [2];

    exp_t        sbq0 [$];
    exp_t        sbq1 [$];
    logic [31:0] mdl [int];
    logic [31:0] last_rd [2];
    logic [31:0] prev_rd [2];
    int          edge_cnt = 0;
    int          total = 0;
    int          bad = 0;

    line_memory_responder u_dut0 (
        .clk(clk), .rst(rst), .req(req_s[0]), .rw(rw_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .rdata(rdata_s[0]), .rdy(rdy_s[0]), .busy(busy_s[0])
    );

    line_memory_responder #(.RD_LAT(1), .WR_LAT(7)) u_dut1 (
        .clk(clk), .rst(rst), .req(req_s[1]), .rw(rw_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .rdata(rdata_s[1]), .rdy(rdy_s[1]), .busy(busy_s[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at edge %0d", tag, got, exp, edge_cnt);
        end
    endtask

    function automatic int lat_of(input int k, input logic rw);
        if (k == 0) return 4;
        return rw ? 7 : 1;
    endfunction

    function automatic int key_of(input int k, input logic [15:0] a);
        logic [13:0] line;
        line = a[15:2];
        return k * 65536 + int'(line);
    endfunction

    function automatic logic [31:0] mdl_rd(input int key);
        return mdl.exists(key) ? mdl[key] : 32'h0;
    endfunction

    // Monitor: reset values, rdy timing/data via scoreboard, rdata hold otherwise.
    always begin
        exp_t e;
        bit   have;
        @(posedge clk);
        edge_cnt++;
        #2;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                check("rst_rdy", 32'(rdy_s[k]), 32'h0);
                check("rst_busy", 32'(busy_s[k]), 32'h0);
                check("rst_rdata", rdata_s[k], 32'h0);
            end else if (rdy_s[k]) begin
                have = 1'b0;
                if (k == 0 && sbq0.size() > 0) begin
                    e = sbq0.pop_front();
                    have = 1'b1;
                end else if (k == 1 && sbq1.size() > 0) begin
                    e = sbq1.pop_front();
                    have = 1'b1;
                end
                if (!have) begin
                    check("extra_rdy", 32'(rdy_s[k]), 32'h0);
                end else begin
                    check("rdy_cycle", 32'(edge_cnt), e.cyc);
                    check("rdata_at_rdy", rdata_s[k], e.rdata);
                end
            end else begin
                check("rdata_hold", rdata_s[k], prev_rd[k]);
            end
            prev_rd[k] = rdata_s[k];
        end
    end

    // Issue one request from an idle DUT; optionally scramble inputs while busy.
    task automatic issue(input int k, input logic rw, input logic [15:0] a,
                         input logic [31:0] d, input bit glitch);
        exp_t e;
        int   t;
        int   lat;
        int   n;
        int   key;
        lat = lat_of(k, rw);
        t   = edge_cnt + 1;
        key = key_of(k, a);
        if (rw) begin
            e.rdata  = last_rd[k];
            mdl[key] = d;
        end else begin
            e.rdata    = mdl_rd(key);
            last_rd[k] = e.rdata;
        end
        e.cyc = 32'(t + lat);
        if (k == 0) sbq0.push_back(e);
        else        sbq1.push_back(e);
        req_s[k]   = 1'b1;
        rw_s[k]    = rw;
        addr_s[k]  = a;
        wdata_s[k] = d;
        @(negedge clk);
        req_s[k] = 1'b0;
        n = 0;
        while (busy_s[k] && n < 100) begin
            n++;
            if (glitch) begin
                rw_s[k]    = 1'($urandom);
                addr_s[k]  = 16'($urandom);
                wdata_s[k] = $urandom;
            end
            @(negedge clk);
        end
        check("busy_cycles", 32'(n), 32'(lat + 1 + TURN));
    endtask

    // Write-back followed by fill with req held high across the turnaround.
    task automatic held_wb_fill();
        exp_t e;
        int   t;
        int   n;
        t = edge_cnt + 1;
        e.cyc   = 32'(t + 4);
        e.rdata = last_rd[0];
        sbq0.push_back(e);
        mdl[key_of(0, 16'h0400)] = 32'hA5A5A5A5;
        e.cyc   = 32'(t + 4 + 1 + TURN + 4);
        e.rdata = mdl_rd(key_of(0, 16'h0800));
        sbq0.push_back(e);
        last_rd[0] = e.rdata;
        req_s[0]   = 1'b1;
        rw_s[0]    = 1'b1;
        addr_s[0]  = 16'h0400;
        wdata_s[0] = 32'hA5A5A5A5;
        n = 0;
        while (edge_cnt < t + 5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        rw_s[0]    = 1'b0;
        addr_s[0]  = 16'h0800;
        wdata_s[0] = 32'h0;
        while (edge_cnt < t + 4 + 1 + TURN && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_s[0] = 1'b0;
        n = 0;
        while (busy_s[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("held_idle", 32'(busy_s[0]), 32'h0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            req_s[k]   = 1'b0;
            rw_s[k]    = 1'b0;
            addr_s[k]  = '0;
            wdata_s[k] = '0;
            last_rd[k] = '0;
            prev_rd[k] = '0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset then read of never-written line.
        issue(0, 1'b0, 16'h0010, 32'h0, 1'b0);

        // Write then read of the same line at a different byte offset.
        issue(0, 1'b1, 16'h1234, 32'hDEADBEEF, 1'b0);
        issue(0, 1'b0, 16'h1236, 32'h0, 1'b0);
        issue(0, 1'b1, 16'h2000, 32'h12345678, 1'b0);
        issue(0, 1'b0, 16'h2000, 32'h0, 1'b0);

        // Write-back then fill with req held.
        held_wb_fill();
        issue(0, 1'b0, 16'h0400, 32'h0, 1'b0);

        // Latency sweep on the RD_LAT=1 / WR_LAT=7 instance.
        issue(1, 1'b1, 16'h0040, 32'h01020304, 1'b0);
        issue(1, 1'b0, 16'h0040, 32'h0, 1'b0);
        issue(1, 1'b0, 16'h0044, 32'h0, 1'b0);
        issue(1, 1'b1, 16'h0044, 32'h55AA55AA, 1'b0);
        issue(1, 1'b0, 16'h0044, 32'h0, 1'b0);

        // Reset two edges into a write's ACCESS phase: write must not commit.
        req_s[0]   = 1'b1;
        rw_s[0]    = 1'b1;
        addr_s[0]  = 16'h0020;
        wdata_s[0] = 32'h11223344;
        @(negedge clk);
        req_s[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy_s[0]), 32'h0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (6) @(negedge clk);
        issue(0, 1'b0, 16'h0020, 32'h0, 1'b0);

        // Inputs scrambled every cycle while busy.
        issue(0, 1'b1, 16'h0100, 32'hCAFEF00D, 1'b1);
        issue(0, 1'b0, 16'h0100, 32'h0, 1'b1);
        issue(1, 1'b1, 16'h0104, 32'h0BADF00D, 1'b1);
        issue(1, 1'b0, 16'h0104, 32'h0, 1'b1);
        issue(0, 1'b0, 16'h1234, 32'h0, 1'b0);

        repeat (4) @(negedge clk);
        check("sbq0_left", 32'(sbq0.size()), 32'h0);
        check("sbq1_left", 32'(sbq1.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
